keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_BITS, default 17, column-dwell counter width; dwell = 2^SCAN_BITS Clk cycles.
REQ-002 SHALL have parameter DEBOUNCE, default 4, consecutive identical frames needed to accept a press or release; legal range 2..15.
REQ-003 SHALL have parameter REPEAT_FRAMES, default 64, frames between auto-repeat pulses; used only under REQ-029.
REQ-004 Clk  input  1  system clock, 100 MHz; all logic on rising edge.
REQ-005 Reset  input  1  synchronous, active-high.
REQ-006 Rows  input  4  keypad row returns, active low, asynchronous, externally pulled up.
REQ-007 Cols  output  4  column strobes, active low, exactly one low at a time.
REQ-008 KeyCode  output  4  last accepted key = {row index[1:0], column index[1:0]}.
REQ-009 KeyValid  output  1  one-cycle pulse per accepted key event.
REQ-010 KeyDown  output  1  level, high while an accepted key is held.

Function
REQ-011 Rows SHALL pass through a 2-flop synchronizer before any use.
REQ-012 Free-running SCAN_BITS counter; "tick" = cycle where counter is all ones.
REQ-013 On each tick: sample synchronized Rows for current column, then rotate Cols left (E->D->B->7->E).
REQ-014 Column index: Cols E=0, D=1, B=2, 7=3; row index = bit position of low Rows bit.
REQ-015 Tick sampling column 3 SHALL end a frame (4 columns); frame classified as NONE (0 low bits), SINGLE (exactly 1, code recorded), or MULTI (>=2, treated as NONE).
REQ-016 FSM states IDLE, PRESS, HELD, RELEASE; evaluated only at frame end.
REQ-017 IDLE: SINGLE -> PRESS, candidate=code, count=1; otherwise stay.
REQ-018 PRESS: SINGLE same code -> count+1; on reaching DEBOUNCE -> HELD, KeyCode=candidate, KeyValid pulse, KeyDown=1. SINGLE different code -> candidate=new, count=1. NONE/MULTI -> IDLE.
REQ-019 HELD: NONE/MULTI -> RELEASE, count=1; SINGLE (any code) -> stay, no new event.
REQ-020 RELEASE: NONE/MULTI -> count+1; on reaching DEBOUNCE -> IDLE, KeyDown=0. SINGLE -> HELD, no pulse.
REQ-021 KeyValid SHALL be high exactly one Clk cycle, the cycle after the accepting frame-end tick; KeyCode updates in that same cycle and holds until next accepted event.
REQ-022 Press latency: KeyValid SHALL assert DEBOUNCE frames after first SINGLE frame, +1 cycle.
REQ-023 Debounce counters SHALL saturate, never wrap.

Reset
REQ-024 Reset SHALL take effect on the next Clk edge, overriding all other activity including mid-PRESS/RELEASE.
REQ-025 Reset values: Cols=4'hE, counter=0, synchronizer=4'hF, KeyCode=0, KeyValid=0, KeyDown=0, FSM=IDLE, all counts=0.
REQ-026 A debounce in progress at Reset SHALL NOT produce KeyValid.

Configuration
REQ-027 Macro KEYPAD_AUTOREPEAT_EN selects auto-repeat.
REQ-028 Without it: one KeyValid per press; HELD never pulses.
REQ-029 With it: while HELD with SINGLE frames of KeyCode, a repeat counter SHALL emit KeyValid every REPEAT_FRAMES frames; cleared on leaving HELD and on Reset.

Verification (SCAN_BITS=3: tick every 8 cycles, frame 32 cycles; DEBOUNCE=4)
REQ-030 Reset asserted 3 cycles -> Cols=4'hE, KeyCode=0, KeyValid=0, KeyDown=0 after first edge.
REQ-031 Rows=4'hD whenever Cols=4'hB, 6 frames -> single KeyValid after 4th frame end, KeyCode=4'h6, KeyDown=1.
REQ-032 Same key pattern 2 frames, 1 empty frame, 4 frames -> exactly one KeyValid, after final frame.
REQ-033 Row0/col0 and row2/col3 pressed together, 8 frames -> no KeyValid, KeyDown=0.
REQ-034 From HELD: 2 empty frames then key again -> KeyDown stays 1, no pulse; then 4 empty frames -> KeyDown=0.
REQ-035 Reset during 3rd PRESS frame -> no KeyValid; Cols=4'hE next cycle; with KEYPAD_AUTOREPEAT_EN, REPEAT_FRAMES=2, holding 10 frames -> pulses at frames 4, 6, 8, 10.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low matrix keypad scanner with frame-based press/release debounce.
// Define KEYPAD_AUTOREPEAT_EN to re-pulse KeyValid every REPEAT_FRAMES frames while a key is held.
module keypad_scanner #(
  parameter int unsigned SCAN_BITS     = 17,
  parameter int unsigned DEBOUNCE      = 4,
  parameter int unsigned REPEAT_FRAMES = 64
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] Rows,
  output logic [3:0] Cols,
  output logic [3:0] KeyCode,
  output logic       KeyValid,
  output logic       KeyDown
);

  typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_t;

  localparam logic [3:0] DEB = 4'(DEBOUNCE);

  logic [3:0]           rows_meta, rows_sync, low;
  logic [SCAN_BITS-1:0] scan_cnt;
  logic                 tick, frame_end, single;
  logic [1:0]           col_idx, row_idx;
  logic [2:0]           n_low;
  logic [1:0]           acc_low, merged_low;
  logic [3:0]           acc_code, merged_code;
  state_t               state, state_n;
  logic [3:0]           cand, cand_n, cnt, cnt_n, cnt_inc;
  logic [3:0]           code_n;
  logic                 valid_n, down_n;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [15:0] REP = 16'(REPEAT_FRAMES);
  logic [15:0]          rep_cnt, rep_n;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rows_meta <= '1;
      rows_sync <= '1;
    end else begin
      rows_meta <= Rows;
      rows_sync <= rows_meta;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      scan_cnt <= '0;
      Cols     <= 4'hE;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      if (tick) Cols <= {Cols[2:0], Cols[3]};
    end
  end

  assign tick      = &scan_cnt;
  assign low       = ~rows_sync;
  assign frame_end = tick && (col_idx == 2'd3);
  assign n_low     = {2'b0, low[0]} + {2'b0, low[1]} + {2'b0, low[2]} + {2'b0, low[3]};

  always_comb begin
    col_idx = 2'd0;
    case (Cols)
      4'hD:    col_idx = 2'd1;
      4'hB:    col_idx = 2'd2;
      4'h7:    col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  always_comb begin
    row_idx = 2'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (low[i]) row_idx = 2'(i);
    end
  end

  // Low-bit count across the frame saturates at 2: anything above one key is MULTI.
  always_comb begin
    merged_low  = acc_low;
    merged_code = acc_code;
    if (n_low >= 3'd2) begin
      merged_low = 2'd2;
    end else if (n_low == 3'd1) begin
      if (acc_low == 2'd0) begin
        merged_low  = 2'd1;
        merged_code = {row_idx, col_idx};
      end else begin
        merged_low = 2'd2;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      acc_low  <= '0;
      acc_code <= '0;
    end else if (tick) begin
      if (frame_end) begin
        acc_low  <= '0;
        acc_code <= '0;
      end else begin
        acc_low  <= merged_low;
        acc_code <= merged_code;
      end
    end
  end

  assign single  = (merged_low == 2'd1);
  assign cnt_inc = (cnt == 4'hF) ? cnt : cnt + 4'd1;

  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    code_n  = KeyCode;
    valid_n = 1'b0;
    down_n  = KeyDown;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_n   = (state == HELD) ? rep_cnt : '0;
`endif
    if (frame_end) begin
      case (state)
        IDLE: begin
          if (single) begin
            state_n = PRESS;
            cand_n  = merged_code;
            cnt_n   = 4'd1;
          end
        end
        PRESS: begin
          if (!single) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else if (merged_code != cand) begin
            cand_n = merged_code;
            cnt_n  = 4'd1;
          end else if (cnt_inc >= DEB) begin
            state_n = HELD;
            code_n  = cand;
            valid_n = 1'b1;
            down_n  = 1'b1;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        HELD: begin
          if (!single) begin
            state_n = RELEASE;
            cnt_n   = 4'd1;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_n   = '0;
          end else if (merged_code == KeyCode) begin
            rep_n = rep_cnt + 16'd1;
            if (rep_n >= REP) begin
              valid_n = 1'b1;
              rep_n   = '0;
            end
          end else begin
            rep_n = '0;
`endif
          end
        end
        RELEASE: begin
          if (single) begin
            state_n = HELD;
            cnt_n   = '0;
          end else if (cnt_inc >= DEB) begin
            state_n = IDLE;
            down_n  = 1'b0;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      cand     <= '0;
      cnt      <= '0;
      KeyCode  <= '0;
      KeyValid <= 1'b0;
      KeyDown  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt  <= '0;
`endif
    end else begin
      state    <= state_n;
      cand     <= cand_n;
      cnt      <= cnt_n;
      KeyCode  <= code_n;
      KeyValid <= valid_n;
      KeyDown  <= down_n;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt  <= rep_n;
`endif
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives an ideal 4x4 keypad frame by frame and checks every cycle
// against a streak-based model of the debounce rules.
module tb_keypad_scanner;
  localparam int unsigned SB = 3;
  localparam int unsigned DB = 4;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RF = 2;
`else
  localparam int unsigned RF = 64;
`endif
  localparam int unsigned TICK  = 1 << SB;
  localparam int unsigned FRAME = 4 * TICK;

  logic       Clk   = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] Rows  = 4'hF;
  logic [3:0] Cols, KeyCode;
  logic       KeyValid, KeyDown;

  keypad_scanner #(.SCAN_BITS(SB), .DEBOUNCE(DB), .REPEAT_FRAMES(RF)) dut (
    .Clk(Clk), .Reset(Reset), .Rows(Rows), .Cols(Cols),
    .KeyCode(KeyCode), .KeyValid(KeyValid), .KeyDown(KeyDown)
  );

  always #5 Clk = ~Clk;

  int          checks = 0;
  int          errors = 0;
  int          dut_pulses = 0;
  logic [15:0] pressed = '0;  // bit index = {row, col}

  // model state
  int unsigned n = 0;
  int unsigned same_run = 0, none_run = 0, rep_run = 0;
  logic [3:0]  last_code = '0, m_code = '0;
  logic        m_valid = 1'b0, m_down = 1'b0;
  bit          started = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int unsigned popc(input logic [15:0] m);
    int unsigned s = 0;
    for (int i = 0; i < 16; i++) if (m[i]) s++;
    return s;
  endfunction

  function automatic logic [3:0] first_idx(input logic [15:0] m);
    logic [3:0] r = '0;
    for (int i = 15; i >= 0; i--) if (m[i]) r = 4'(i);
    return r;
  endfunction

  function automatic logic [3:0] strobe(input int unsigned cyc);
    int unsigned c = (cyc / TICK) % 4;
    logic [3:0] one = 4'b0001;
    return ~(one << c);
  endfunction

  function automatic logic [3:0] rows_for(input logic [3:0] cols, input logic [15:0] m);
    logic [3:0] r = 4'hF;
    int c = 0;
    for (int i = 0; i < 4; i++) if (cols[i] === 1'b0) c = i;
    for (int i = 0; i < 4; i++) if (m[i*4 + c]) r[i] = 1'b0;
    return r;
  endfunction

  // Streak view of the rules: accept after DB consecutive same-code SINGLE frames while up,
  // release after DB consecutive non-SINGLE frames while down.
  task automatic eval_frame();
    int unsigned k = popc(pressed);
    logic [3:0]  code = first_idx(pressed);
    bit          single = (k == 1);
    bit          down_before = m_down;
    int unsigned none_before = none_run;
    if (single) begin
      same_run  = (same_run > 0 && code == last_code) ? same_run + 1 : 1;
      last_code = code;
      none_run  = 0;
    end else begin
      same_run = 0;
      none_run++;
    end
    if (!down_before) begin
      rep_run = 0;
      if (same_run == DB) begin
        m_valid = 1'b1;
        m_code  = code;
        m_down  = 1'b1;
      end
    end else begin
      if (none_run == DB) m_down = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      if (single && code == m_code && none_before == 0) begin
        rep_run++;
        if (rep_run == RF) begin
          m_valid = 1'b1;
          rep_run = 0;
        end
      end else begin
        rep_run = 0;
      end
`else
      if (none_before > 0) rep_run = 0;
`endif
    end
  endtask

  initial begin
    forever begin
      @(posedge Clk);
      if (Reset) begin
        n = 0; same_run = 0; none_run = 0; rep_run = 0;
        last_code = '0; m_code = '0; m_valid = 1'b0; m_down = 1'b0;
        started = 1;
      end else begin
        n++;
        m_valid = 1'b0;
        if (n % FRAME == 0) eval_frame();
      end
      #1;
      if (started) begin
        check("cols",      32'(Cols),     32'(strobe(n)));
        check("key_valid", 32'(KeyValid), 32'(m_valid));
        check("key_code",  32'(KeyCode),  32'(m_code));
        check("key_down",  32'(KeyDown),  32'(m_down));
        if (KeyValid === 1'b1) dut_pulses++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge Clk);
      #2;
      Rows = rows_for(Cols, pressed);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic run_frames(input logic [15:0] mask, input int unsigned k);
    int unsigned guard;
    for (int unsigned f = 0; f < k; f++) begin
      pressed = mask;
      guard = 0;
      do begin
        @(negedge Clk);
        guard++;
      end while (n % FRAME != 0 && guard < 2 * FRAME);
      if (guard >= 2 * FRAME) check("frame_sync", 32'(guard), 32'(FRAME));
    end
  endtask

  int p0;
  logic [15:0] m;
  int unsigned total, len, kind;
  logic [3:0] b1, b2;

  initial begin
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_cols", 32'(Cols), 32'h0000000E);
    check("rst_code", 32'(KeyCode), 32'h0);
    check("rst_valid", 32'(KeyValid), 32'h0);
    check("rst_down", 32'(KeyDown), 32'h0);
    Reset = 1'b0;

    // row1/col2 held 6 frames
    p0 = dut_pulses;
    run_frames(16'h0040, 6);
`ifdef KEYPAD_AUTOREPEAT_EN
    check("hold6_pulses", 32'(dut_pulses - p0), 32'd2);
`else
    check("hold6_pulses", 32'(dut_pulses - p0), 32'd1);
`endif
    check("hold6_code", 32'(KeyCode), 32'h6);
    check("hold6_down", 32'(KeyDown), 32'h1);
    run_frames(16'h0000, 4);
    check("release_down", 32'(KeyDown), 32'h0);

    // bounce: 2 frames, gap, 4 frames
    p0 = dut_pulses;
    run_frames(16'h0002, 2);
    run_frames(16'h0000, 1);
    run_frames(16'h0002, 3);
    check("bounce_early", 32'(dut_pulses - p0), 32'd0);
    run_frames(16'h0002, 1);
    check("bounce_pulses", 32'(dut_pulses - p0), 32'd1);
    check("bounce_code", 32'(KeyCode), 32'h1);
    run_frames(16'h0000, 4);

    // two keys together
    p0 = dut_pulses;
    run_frames(16'h0801, 8);
    check("multi_pulses", 32'(dut_pulses - p0), 32'd0);
    check("multi_down", 32'(KeyDown), 32'h0);

    // held, short gap, key again, full release
    p0 = dut_pulses;
    run_frames(16'h8000, 4);
    run_frames(16'h0000, 2);
    run_frames(16'h8000, 1);
    check("regrab_down", 32'(KeyDown), 32'h1);
    check("regrab_pulses", 32'(dut_pulses - p0), 32'd1);
    run_frames(16'h0000, 4);
    check("regrab_release", 32'(KeyDown), 32'h0);

    // candidate change during debounce
    p0 = dut_pulses;
    run_frames(16'h0008, 2);
    run_frames(16'h1000, 4);
    check("switch_pulses", 32'(dut_pulses - p0), 32'd1);
    check("switch_code", 32'(KeyCode), 32'hC);
    run_frames(16'h0000, 4);

    // reset in the middle of the third debounce frame
    p0 = dut_pulses;
    run_frames(16'h0040, 2);
    repeat (16) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check("midrst_cols", 32'(Cols), 32'h0000000E);
    check("midrst_valid", 32'(KeyValid), 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    check("midrst_pulses", 32'(dut_pulses - p0), 32'd0);
    run_frames(16'h0040, 10);
`ifdef KEYPAD_AUTOREPEAT_EN
    check("repeat_pulses", 32'(dut_pulses - p0), 32'd4);
`else
    check("repeat_pulses", 32'(dut_pulses - p0), 32'd1);
`endif
    run_frames(16'h0000, 4);

    // random keying
    total = 0;
    while (total < 120) begin
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 6);
      b1   = 4'($urandom_range(0, 15));
      b2   = b1 + 4'($urandom_range(1, 15));
      m    = '0;
      if (kind >= 4 && kind <= 8) begin
        m[b1] = 1'b1;
      end else if (kind == 9) begin
        m[b1] = 1'b1;
        m[b2] = 1'b1;
      end
      run_frames(m, len);
      total += len;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
